cart_bus_arbiter: RTL and testbench

Shares the single cart_iface ROM/RAM access port between three requesters: startup screen generator (0), splash generator (1) and SPI cart bridge (2). It replaces the phase-based combinational mux with a registered round-robin arbiter. Each access runs the rd/wr strobe and busy handshake. The arbiter returns read data with a one-cycle ack per requester. Sits between the requesters and cart_iface in the clk_8m domain.

---
 rtl/cart_bus_arbiter_if.sv | 30 +++
 rtl/cart_bus_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_cart_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_bus_arbiter_if.sv
// Signal bundle between the three cart requesters, the arbiter and cart_iface.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface cart_bus_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  req_wr;
    logic [47:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  ena_mask;
    logic [2:0]  ack;
    logic [7:0]  rdata;
    logic        err;
    logic [1:0]  grant_id;
    logic        idle;
    logic [15:0] c_addr;
    logic        c_rd;
    logic        c_wr;
    logic [7:0]  c_din;
    logic [7:0]  c_dout;
    logic        c_busy;

    modport slave (
        input  req, req_wr, req_addr, req_wdata, ena_mask, c_dout, c_busy,
        output ack, rdata, err, grant_id, idle, c_addr, c_rd, c_wr, c_din
    );

    modport master (
        output req, req_wr, req_addr, req_wdata, ena_mask, c_dout, c_busy,
        input  ack, rdata, err, grant_id, idle, c_addr, c_rd, c_wr, c_din
    );
endinterface

// File: rtl/cart_bus_arbiter.sv
// Registered round-robin arbiter sharing the cart_iface port between three requesters.
// Each grant runs one strobe / busy-rise / busy-fall handshake and ends with a one-cycle ack.
module cart_bus_arbiter #(
    parameter int NREQ        = 3,
    parameter int BSY_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic                 clk_8m,
    input  logic                 rst,
    cart_bus_arbiter_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BSY_TIMEOUT - 1);

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        onehot = NREQ'(1'b1) << idx;
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              wr_q, wr_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rd_stb_q, rd_stb_d;
    logic              wr_stb_q, wr_stb_d;
    logic              idle_q, idle_d;

    logic [NREQ-1:0]   elig_s;
    logic              found_s;
    logic [1:0]        win_s;
    logic [15:0]       sel_addr_s;
    logic [7:0]        sel_wdata_s;
    logic              sel_wr_s;

    // Round-robin pick: search begins one past the last owner and wraps.
    always_comb begin
        elig_s  = bus.req & bus.ena_mask;
        found_s = |elig_s;
        win_s   = 2'd0;
        case (grant_q)
            2'd0: begin
                if (elig_s[1])      win_s = 2'd1;
                else if (elig_s[2]) win_s = 2'd2;
                else                win_s = 2'd0;
            end
            2'd1: begin
                if (elig_s[2])      win_s = 2'd2;
                else if (elig_s[0]) win_s = 2'd0;
                else                win_s = 2'd1;
            end
            default: begin
                if (elig_s[0])      win_s = 2'd0;
                else if (elig_s[1]) win_s = 2'd1;
                else                win_s = 2'd2;
            end
        endcase
    end

    // Select the winner's address, write byte and direction.
    always_comb begin
        sel_addr_s  = bus.req_addr[15:0];
        sel_wdata_s = bus.req_wdata[7:0];
        sel_wr_s    = bus.req_wr[0];
        case (win_s)
            2'd1: begin
                sel_addr_s  = bus.req_addr[31:16];
                sel_wdata_s = bus.req_wdata[15:8];
                sel_wr_s    = bus.req_wr[1];
            end
            2'd2: begin
                sel_addr_s  = bus.req_addr[47:32];
                sel_wdata_s = bus.req_wdata[23:16];
                sel_wr_s    = bus.req_wr[2];
            end
            default: begin
                sel_addr_s  = bus.req_addr[15:0];
                sel_wdata_s = bus.req_wdata[7:0];
                sel_wr_s    = bus.req_wr[0];
            end
        endcase
    end

    // Next-state and next-output logic; strobes and ack are decoded one cycle early so they leave registers.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        din_d    = din_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    grant_d  = win_s;
                    addr_d   = sel_addr_s;
                    din_d    = sel_wdata_s;
                    wr_d     = sel_wr_s;
                    rd_stb_d = ~sel_wr_s;
                    wr_stb_d = sel_wr_s;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (bus.c_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    ack_d   = onehot(grant_q);
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + TO_W'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!bus.c_busy) begin
                    if (!wr_q) begin
                        rdata_d = bus.c_dout;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    ack_d   = onehot(grant_q);
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        idle_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_8m) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'd2;
            addr_q   <= 16'h0000;
            din_q    <= 8'h00;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            ack_q    <= '0;
            rdata_q  <= 8'h00;
            err_q    <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            idle_q   <= idle_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.rdata    = rdata_q;
    assign bus.err      = err_q;
    assign bus.grant_id = grant_q;
    assign bus.idle     = idle_q;
    assign bus.c_addr   = addr_q;
    assign bus.c_rd     = rd_stb_q;
    assign bus.c_wr     = wr_stb_q;
    assign bus.c_din    = din_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Scoreboard bench for cart_bus_arbiter: a cart model answers strobes with busy pulses,
// expected grants are queued at stimulus time and popped on every ack.
module tb_cart_bus_arbiter;

    typedef struct {
        int          idx;
        logic [15:0] addr;
        logic        rd;
        logic [7:0]  rdata;
        logic [7:0]  din;
    } exp_t;

    logic clk_8m;
    logic rst;
    cart_bus_arbiter_if bus ();

    cart_bus_arbiter #(.NREQ(3), .BSY_TIMEOUT(15), .TO_W(4)) dut (
        .clk_8m (clk_8m),
        .rst    (rst),
        .bus    (bus.slave)
    );

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   pend[3];
    int   busy_len = 1;
    logic busy_en = 1'b1;
    logic [2:0] prev_ack = 3'b000;

    initial begin
        clk_8m = 1'b0;
        forever #5 clk_8m = ~clk_8m;
    end

    always @(posedge clk_8m) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_8m);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic push(input int idx, input logic [15:0] addr, input logic rd,
                        input logic [7:0] rdata, input logic [7:0] din);
        exp_t e;
        e.idx = idx; e.addr = addr; e.rd = rd; e.rdata = rdata; e.din = din;
        sb.push_back(e);
    endtask

    // Cart model: busy rises the cycle after a strobe and stays high busy_len cycles.
    initial begin
        forever begin
            @(posedge clk_8m);
            #1;
            if (busy_en && (bus.c_rd || bus.c_wr)) begin
                @(posedge clk_8m);
                #1;
                bus.c_busy = 1'b1;
                repeat (busy_len) @(posedge clk_8m);
                #1;
                bus.c_busy = 1'b0;
            end
        end
    end

    // Monitor: counts strobe cycles, checks every ack against the scoreboard, retires requests.
    initial begin
        exp_t e;
        logic [2:0] one;
        one = 3'b001;
        forever begin
            @(posedge clk_8m);
            #1;
            rd_cnt += int'(bus.c_rd);
            wr_cnt += int'(bus.c_wr);
            if (bus.ack != 3'b000) begin
                check_eq("ack_width", {29'd0, prev_ack}, 32'd0);
                if (sb.size() == 0) begin
                    check_eq("ack_unexp", {29'd0, bus.ack}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("ack_vec", {29'd0, bus.ack}, {29'd0, one << e.idx});
                    check_eq("grant_at_ack", {30'd0, bus.grant_id}, e.idx);
                    check_eq("addr_at_ack", {16'd0, bus.c_addr}, {16'd0, e.addr});
                    if (e.rd) check_eq("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
                    else      check_eq("din", {24'd0, bus.c_din}, {24'd0, e.din});
                    last_ack_cyc = cyc;
                end
                for (int i = 0; i < 3; i++) begin
                    if (bus.ack[i] && pend[i] > 0) begin
                        pend[i]--;
                        if (pend[i] == 0) bus.req[i] = 1'b0;
                    end
                end
            end
            prev_ack = bus.ack;
        end
    end

    initial begin
        int t0;
        for (int i = 0; i < 3; i++) pend[i] = 0;
        bus.req = 3'b000; bus.req_wr = 3'b000; bus.req_addr = 48'd0; bus.req_wdata = 24'd0;
        bus.ena_mask = 3'b111; bus.c_dout = 8'h00; bus.c_busy = 1'b0;

        // Reset state.
        rst = 1'b1;
        tick(); tick();
        check_eq("rst_idle", {31'd0, bus.idle}, 32'd1);
        check_eq("rst_ack", {29'd0, bus.ack}, 32'd0);
        check_eq("rst_err", {31'd0, bus.err}, 32'd0);
        check_eq("rst_grant", {30'd0, bus.grant_id}, 32'd2);
        check_eq("rst_rdata", {24'd0, bus.rdata}, 32'd0);
        check_eq("rst_addr", {16'd0, bus.c_addr}, 32'd0);
        check_eq("rst_din", {24'd0, bus.c_din}, 32'd0);
        check_eq("rst_strobes", {30'd0, bus.c_rd, bus.c_wr}, 32'd0);
        rst = 1'b0;
        tick();

        // Single read with a three-cycle busy.
        busy_len = 3; bus.c_dout = 8'hA5;
        bus.req_addr[15:0] = 16'h0134;
        rd_cnt = 0; wr_cnt = 0;
        push(0, 16'h0134, 1'b1, 8'hA5, 8'h00);
        pend[0] = 1; bus.req = 3'b001;
        wait_drain(40);
        check_eq("rd1_rd_pulses", rd_cnt, 1);
        check_eq("rd1_wr_pulses", wr_cnt, 0);
        check_eq("rd1_err", {31'd0, bus.err}, 32'd0);
        check_eq("rd1_rdata_hold", {24'd0, bus.rdata}, 32'hA5);

        // Write from requester 2; rdata must keep the last read byte.
        busy_len = 1;
        bus.req_wr = 3'b100; bus.req_addr[47:32] = 16'h2000; bus.req_wdata[23:16] = 8'h3C;
        tick();
        rd_cnt = 0; wr_cnt = 0;
        push(2, 16'h2000, 1'b0, 8'h00, 8'h3C);
        pend[2] = 1; bus.req = 3'b100;
        t0 = cyc;
        wait_drain(40);
        check_eq("wr_latency", last_ack_cyc - t0, 4);
        check_eq("wr_wr_pulses", wr_cnt, 1);
        check_eq("wr_rd_pulses", rd_cnt, 0);
        check_eq("wr_rdata_kept", {24'd0, bus.rdata}, 32'hA5);

        // Contention: three continuous readers, pointer starts after owner 2.
        bus.req_wr = 3'b000; bus.c_dout = 8'h5A;
        bus.req_addr = {16'h2222, 16'h1111, 16'h0000};
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            push(0, 16'h0000, 1'b1, 8'h5A, 8'h00);
            push(1, 16'h1111, 1'b1, 8'h5A, 8'h00);
            push(2, 16'h2222, 1'b1, 8'h5A, 8'h00);
        end
        rd_cnt = 0;
        pend[0] = 2; pend[1] = 2; pend[2] = 2; bus.req = 3'b111;
        wait_drain(200);
        check_eq("cont_rd_pulses", rd_cnt, 6);
        check_eq("cont_req_dropped", {29'd0, bus.req}, 32'd0);

        // Mask: requester 0 held off until its enable returns.
        tick(); tick();
        bus.c_dout = 8'h77; bus.ena_mask = 3'b010;
        push(1, 16'h1111, 1'b1, 8'h77, 8'h00);
        pend[0] = 1; pend[1] = 1; bus.req = 3'b011;
        wait_drain(40);
        repeat (8) tick();
        check_eq("mask_idle", {31'd0, bus.idle}, 32'd1);
        check_eq("mask_grant", {30'd0, bus.grant_id}, 32'd1);
        push(0, 16'h0000, 1'b1, 8'h77, 8'h00);
        bus.ena_mask = 3'b011;
        wait_drain(40);
        check_eq("mask_grant0", {30'd0, bus.grant_id}, 32'd0);

        // Busy timeout: ack still pulses, err sticks, rdata untouched.
        tick(); tick();
        busy_en = 1'b0; bus.c_dout = 8'hEE;
        bus.ena_mask = 3'b111;
        push(0, 16'h0000, 1'b1, 8'h77, 8'h00);
        pend[0] = 1; bus.req = 3'b001;
        t0 = cyc;
        wait_drain(60);
        check_eq("to_latency", last_ack_cyc - t0, 17);
        check_eq("to_err", {31'd0, bus.err}, 32'd1);
        busy_en = 1'b1; bus.c_dout = 8'h11;
        tick(); tick();
        push(1, 16'h1111, 1'b1, 8'h11, 8'h00);
        pend[1] = 1; bus.req = 3'b010;
        wait_drain(40);
        check_eq("to_err_sticky", {31'd0, bus.err}, 32'd1);

        // Reset while in WAIT_LO, then a normal access.
        tick(); tick();
        busy_len = 3; bus.c_dout = 8'h99;
        pend[0] = 1; bus.req = 3'b001;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 3'b000; pend[0] = 0;
        check_eq("mrst_idle", {31'd0, bus.idle}, 32'd1);
        check_eq("mrst_ack", {29'd0, bus.ack}, 32'd0);
        check_eq("mrst_err", {31'd0, bus.err}, 32'd0);
        check_eq("mrst_grant", {30'd0, bus.grant_id}, 32'd2);
        repeat (6) tick();
        check_eq("mrst_no_ack", sb.size(), 0);
        busy_len = 1; bus.c_dout = 8'h42;
        push(0, 16'h0000, 1'b1, 8'h42, 8'h00);
        pend[0] = 1; bus.req = 3'b001;
        wait_drain(40);
        check_eq("post_rst_rdata", {24'd0, bus.rdata}, 32'h42);
        check_eq("post_rst_err", {31'd0, bus.err}, 32'd0);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
